gate_sweep_checker: RTL
=======================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter N, default 2: gate input count, legal range 1..8.
REQ-002 SHALL have parameter SETTLE, default 2: wait cycles per vector before sampling, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE.
REQ-006 SHALL have port mode, input, 3 bits: gate under test; 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR; 6 and 7 are illegal.
REQ-007 SHALL have port dut_y, input, 1 bit: output of the external N-input gate under test.
REQ-008 SHALL have port vec_out, output, N bits: stimulus to the gate inputs; bit 0 is input a.
REQ-009 SHALL have port busy, output, 1 bit: high while in DRIVE or SAMPLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 SHALL have port pass, output, 1 bit: result of the last sweep.
REQ-012 SHALL have port err_count, output, N+1 bits: mismatches in the last or current sweep.
REQ-013 SHALL have port first_fail, output, N bits: first mismatching vector.
REQ-014 SHALL have port fail_seen, output, 1 bit: high once first_fail is valid.
REQ-015 SHALL have port expected, output, 1 bit: reference gate result for vec_out and the latched mode.

Function
REQ-016 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-017 SHALL, in IDLE with start=1 and a legal mode: latch mode; set vec_out=0, settle counter=0, err_count=0 and fail_seen=0; go to DRIVE.
REQ-018 SHALL, in IDLE with start=1 and an illegal mode: go to DONE with pass=0 and err_count=0.
REQ-019 SHALL hold DRIVE for exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SHALL, in SAMPLE, compare dut_y with expected; on mismatch, increment err_count and, if fail_seen=0, load first_fail=vec_out and set fail_seen=1.
REQ-021 SHALL, after SAMPLE, go to DONE if vec_out equals all-ones; otherwise increment vec_out and return to DRIVE.
REQ-022 SHALL take exactly 2^N*(SETTLE+1) busy cycles per sweep; defaults give 12.
REQ-023 SHALL spend one cycle in DONE with done=1, set pass = (err_count==0) from the final count, then go to IDLE.
REQ-024 SHALL hold pass, err_count, first_fail and fail_seen stable in IDLE until the next accepted start.
REQ-025 SHALL ignore start while busy or in DONE.
REQ-026 SHALL use the latched mode only; changes on mode mid-sweep have no effect.
REQ-027 SHALL hold vec_out at its last value in DONE and IDLE.
REQ-028 SHALL produce expected combinationally from vec_out and the latched mode, with zero latency.
REQ-029 SHALL size err_count to N+1 bits so the worst case of 2^N cannot wrap.

Reset
REQ-030 SHALL, on rst=1 at a clock edge from any state including mid-sweep, go to IDLE.
REQ-031 SHALL reset vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0 and the latched mode to 0.
REQ-032 SHALL give rst priority over start in the same cycle.

Structure
REQ-033 SHALL place the mode encodings (MODE_NOR..MODE_XNOR) and the FSM state encodings in the shared package gate_pkg.
REQ-034 SHALL implement the expected-value model as the sub-module gate_nin: combinational, parameter N, inputs vec and mode, output y.
REQ-035 SHALL keep all sequential logic in gate_sweep_checker, with one clocked process.

Verification
REQ-036 SHALL cover: N=2, SETTLE=2, mode=0, ideal NOR as DUT -> done 13 cycles after the start edge, pass=1, err_count=0, fail_seen=0.
REQ-037 SHALL cover: N=2, mode=0, dut_y stuck at 0 -> err_count=1, first_fail=2'b00, pass=0.
REQ-038 SHALL cover: N=3, mode=4, dut_y stuck at 1 -> err_count=4, first_fail=3'b000, pass=0.
REQ-039 SHALL cover: mode=6 with start -> done on the next cycle, pass=0, busy never asserted.
REQ-040 SHALL cover: rst at cycle 5 of a sweep, then start with mode=0 held during the sweep while mode toggles to 2 -> all outputs at reset values, then a clean full sweep using NOR, pass=1.
REQ-041 SHALL cover: start pulsed repeatedly during a sweep -> exactly one done pulse and an unchanged cycle count of 12.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared encodings for the gate sweep checker: gate modes, FSM states, counter widths.
package gate_pkg;

   localparam int unsigned MODE_W   = 3;
   localparam int unsigned SETTLE_W = 4;

   localparam logic [MODE_W-1:0] MODE_NOR  = 3'd0;
   localparam logic [MODE_W-1:0] MODE_NAND = 3'd1;
   localparam logic [MODE_W-1:0] MODE_AND  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_OR   = 3'd3;
   localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic mode_legal(input logic [MODE_W-1:0] m);
      return (m <= MODE_XNOR);
   endfunction

endpackage

// File: rtl/gate_nin.sv
// Reference N-input gate: combinational model of the gate selected by mode.
module gate_nin
   import gate_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]      vec,
   input  logic [MODE_W-1:0] mode,
   output logic              y
);

   always_comb begin
      y = 1'b0;
      case (mode)
         MODE_NOR:  y = ~(|vec);
         MODE_NAND: y = ~(&vec);
         MODE_AND:  y = &vec;
         MODE_OR:   y = |vec;
         MODE_XOR:  y = ^vec;
         MODE_XNOR: y = ~(^vec);
         default:   y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustively sweeps all 2^N input vectors into an external gate and checks its
// output against the reference model, reporting error count and first failing vector.
module gate_sweep_checker
   import gate_pkg::*;
#(
   parameter int unsigned N      = 2,
   parameter int unsigned SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MODE_W-1:0] mode,
   input  logic              dut_y,
   output logic [N-1:0]      vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N:0]        err_count,
   output logic [N-1:0]      first_fail,
   output logic              fail_seen,
   output logic              expected
);

   localparam int unsigned          CNT_W       = N + 1;
   localparam logic [N-1:0]         VEC_LAST    = '1;
   localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE - 1);

   state_e              state_q, state_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [N-1:0]        vec_q, vec_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [CNT_W-1:0]    err_q, err_d;
   logic [N-1:0]        ff_q, ff_d;
   logic                seen_q, seen_d;

   gate_nin #(.N(N)) u_ref (
      .vec  (vec_q),
      .mode (mode_q),
      .y    (expected)
   );

   // Next-state and result bookkeeping; pass is resolved on entry to DONE so it
   // is already valid while done pulses.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      pass_d   = pass_q;
      err_d    = err_q;
      ff_d     = ff_q;
      seen_d   = seen_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mode_legal(mode)) begin
                  mode_d   = mode;
                  vec_d    = '0;
                  settle_d = '0;
                  err_d    = '0;
                  seen_d   = 1'b0;
                  state_d  = ST_DRIVE;
               end else begin
                  pass_d  = 1'b0;
                  err_d   = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = ST_SAMPLE;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (dut_y != expected) begin
               err_d = err_q + CNT_W'(1);
               if (!seen_q) begin
                  ff_d   = vec_q;
                  seen_d = 1'b1;
               end
            end
            if (vec_q == VEC_LAST) begin
               pass_d  = (err_d == '0);
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + N'(1);
               state_d = ST_DRIVE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= '0;
         vec_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         ff_q     <= '0;
         seen_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ff_q     <= ff_d;
         seen_q   <= seen_d;
      end
   end

   assign vec_out    = vec_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;
   assign fail_seen  = seen_q;

endmodule
